// File: rtl/sum_accumulator_pkg.sv
// Shared types and default widths for the frame sum accumulator.
package sum_accumulator_pkg;
  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;
endpackage

// File: rtl/sum_accumulator_adder.sv
// WIDTH-bit ripple-carry adder stage: per-bit full adders chained through c[].
module acc_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/sum_accumulator.sv
// Frames a stream of operands into one {sum, sticky overflow, beat count} result
// per frame; in_ready/out_valid are registered decodes of the two-state FSM.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);
  state_t           state;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] s;
  logic             c;
  logic             ovf_n;
  logic [CNT_W-1:0] cnt_n;
  logic             xfer;
  logic             close;

  acc_adder #(.WIDTH(WIDTH)) u_add (
    .a    (acc),
    .b    (in_data),
    .sum  (s),
    .cout (c)
  );

  assign xfer  = in_valid && in_ready;
  assign ovf_n = ovf | c;
  assign cnt_n = cnt + 1'b1;
  // A full counter forces the frame shut regardless of in_last.
  assign close = in_last || (cnt_n == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ACCUM: begin
          if (xfer) begin
            if (close) begin
              out_sum   <= s;
              out_ovf   <= ovf_n;
              out_cnt   <= cnt_n;
              acc       <= '0;
              ovf       <= 1'b0;
              cnt       <= '0;
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              acc <= s;
              ovf <= ovf_n;
              cnt <= cnt_n;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: table of beats with expected frame results,
// plus hand sequences for reset, backpressure and upstream stalls.
module tb_sum_accumulator;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic [3:0] out_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       done;
    logic [7:0] sum;
    logic       ovf;
    logic [3:0] cnt;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sum_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic last, input logic done,
                     input logic [7:0] sum, input logic ovf, input logic [3:0] cnt);
    vec_t v;
    v.d = d; v.last = last; v.done = done; v.sum = sum; v.ovf = ovf; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input logic [7:0] d, input logic last);
    bit ok = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int k = 0; k < 20; k++) begin
      ok = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (ok) break;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_res(input string name, input logic [7:0] s, input logic o, input logic [3:0] c);
    check({name, "_valid"}, out_valid, 1'b1);
    check({name, "_sum"},   out_sum,   s);
    check({name, "_ovf"},   out_ovf,   o);
    check({name, "_cnt"},   out_cnt,   c);
    check({name, "_inrdy"}, in_ready,  1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_inrdy", in_ready, 1'b1);
    check("rst_ovld",  out_valid, 1'b0);
    check("rst_sum",   out_sum, 8'd0);
    check("rst_ovf",   out_ovf, 1'b0);
    check("rst_cnt",   out_cnt, 4'd0);
    rst = 1'b0;

    // Table: basic, overflow, recovery, forced close, new frame, wrap cases.
    add(8'd3, 0, 0, 0, 0, 0);
    add(8'd5, 0, 0, 0, 0, 0);
    add(8'd7, 1, 1, 8'd15, 0, 4'd3);
    add(8'd200, 0, 0, 0, 0, 0);
    add(8'd100, 1, 1, 8'd44, 1, 4'd2);
    add(8'd1, 1, 1, 8'd1, 0, 4'd1);
    for (int i = 0; i < 14; i++) add(8'd1, 0, 0, 0, 0, 0);
    add(8'd1, 0, 1, 8'd15, 0, 4'd15);
    add(8'd2, 1, 1, 8'd2, 0, 4'd1);
    add(8'd255, 0, 0, 0, 0, 0);
    add(8'd255, 1, 1, 8'd254, 1, 4'd2);
    add(8'd255, 0, 0, 0, 0, 0);
    add(8'd1, 0, 0, 0, 0, 0);
    add(8'd0, 1, 1, 8'd0, 1, 4'd3);
    for (int i = 0; i < 14; i++) add(8'd2, 0, 0, 0, 0, 0);
    add(8'd2, 1, 1, 8'd30, 0, 4'd15);

    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].last);
      if (vecs[i].done) begin
        check_res($sformatf("vec%0d", i), vecs[i].sum, vecs[i].ovf, vecs[i].cnt);
        @(posedge clk); @(negedge clk);
        check($sformatf("vec%0d_bubble_end", i), out_valid, 1'b0);
        check($sformatf("vec%0d_inrdy_back", i), in_ready, 1'b1);
      end else begin
        check($sformatf("vec%0d_novld", i), out_valid, 1'b0);
      end
    end

    // Backpressure, with an operand waiting upstream throughout HOLD.
    out_ready = 1'b0;
    send(8'd6, 1);
    in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_res($sformatf("bp%0d", k), 8'd6, 1'b0, 4'd1);
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("bp_release_ovld", out_valid, 1'b0);
    check("bp_release_inrdy", in_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check_res("bp_next", 8'd99, 1'b0, 4'd1);
    @(posedge clk); @(negedge clk);

    // Reset mid-frame discards the partial sum.
    send(8'd9, 0);
    send(8'd9, 0);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("midrst_inrdy", in_ready, 1'b1);
    send(8'd4, 1);
    check_res("midrst", 8'd4, 1'b0, 4'd1);
    @(posedge clk); @(negedge clk);

    // Upstream stall: idle cycles leave acc/cnt untouched.
    send(8'd10, 0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    check("stall_novld", out_valid, 1'b0);
    send(8'd20, 1);
    check_res("stall", 8'd30, 1'b0, 4'd2);
    @(posedge clk); @(negedge clk);

    // Reset while holding a result drops it.
    out_ready = 1'b0;
    send(8'd50, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    check("holdrst_ovld", out_valid, 1'b0);
    check("holdrst_inrdy", in_ready, 1'b1);
    check("holdrst_sum", out_sum, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Accumulates a stream of 8-bit operands into a running sum, one operand per accepted beat, and emits one result per frame with a sticky overflow flag and a beat count. It sits directly downstream of the 8-bit adder datapath: the per-beat add (sum plus carry-out) is performed by an internal adder stage, and this block registers the sum, folds the carry into overflow and frames the results. Input and output use valid/ready handshakes.

## Interface
- WIDTH, 8, operand and sum width.
- CNT_W, 4, beat-counter width. The maximum frame length is 2^CNT_W-1 beats.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  the upstream operand is valid.
- in_ready  out  1  the block accepts an operand this cycle.
- in_data  in  WIDTH  operand.
- in_last  in  1  marks the final beat of a frame; qualified by the transfer.
- out_valid  out  1  a frame result is presented.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  frame sum, modulo 2^WIDTH.
- out_ovf  out  1  set if any add in the frame produced a carry-out.
- out_cnt  out  CNT_W  number of beats in the frame.

## Operation
- The FSM has two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Reset state:
  - FSM in ACCUM.
  - acc=0, ovf=0, cnt=0.
  - out_sum=0, out_ovf=0, out_cnt=0, out_valid=0, in_ready=1 (from the cycle after rst is sampled).
- A transfer is in_valid && in_ready.
- On a transfer in ACCUM:
  - {c,s} = acc + in_data, computed at full WIDTH+1 width.
  - ovf_n = ovf | c.
  - cnt_n = cnt + 1.
- Frame close: the frame closes when the transfer has in_last=1, or when cnt_n == 2^CNT_W-1 (forced close; in_last is ignored on that beat).
- If the frame does not close: acc<=s, ovf<=ovf_n, cnt<=cnt_n, and the FSM stays in ACCUM.
- If the frame closes:
  - out_sum<=s, out_ovf<=ovf_n, out_cnt<=cnt_n.
  - acc, ovf and cnt are cleared to 0.
  - The FSM moves to HOLD.
- In HOLD:
  - out_* stay stable until out_valid && out_ready.
  - On that handshake, the FSM returns to ACCUM.
  - out_sum, out_ovf and out_cnt keep their last values; they are don't-care while out_valid=0.
- out_ready while out_valid=0 is ignored.
- in_valid in HOLD is not accepted. Upstream must hold in_valid and in_data per the handshake.
- rst asserted mid-frame or in HOLD discards the partial sum and any pending result. The state returns to the reset values on the next edge.
- The carry wraps: the sum is modulo 2^WIDTH, and overflow is sticky only within a frame.

## Timing
- Latency: last beat accepted at edge N gives out_valid=1 after edge N, visible in cycle N+1.
- Throughput:
  - One operand per cycle within a frame.
  - Each frame result costs at least one HOLD cycle with in_ready=0.
  - A consumer with out_ready held at 1 sees one bubble per frame.
- in_ready and out_valid are registered state decodes, with no combinational path from in_valid or out_ready.
- The adder path (acc + in_data) is combinational within one cycle. No pipelining.

## Structure
- Package sum_accumulator_pkg:
  - state enum {ACCUM, HOLD}.
  - default WIDTH and CNT_W constants.
- Sub-module acc_adder: WIDTH-bit combinational adder with a, b inputs and sum, cout outputs. Its ripple structure matches the team's existing adder cells. The top block holds the FSM, registers and handshake.

## Test plan
- Basic frame: beats 3, 5, 7 (last on 7), out_ready=1 → out_sum=15, out_ovf=0, out_cnt=3, out_valid for exactly 1 cycle, one cycle after the 7 is accepted.
- Overflow frame: beats 200, 100 (last) → out_sum=44, out_ovf=1, out_cnt=2. A following frame of 1 (last) → out_sum=1, out_ovf=0, out_cnt=1.
- Forced close (CNT_W=4): 15 beats of 1, in_last never set → out_sum=15, out_cnt=15, out_ovf=0. The next beat begins a new frame.
- Backpressure: hold out_ready=0 for 5 cycles after a result → out_* stable, in_ready=0 throughout. Raise out_ready → handshake, then in_ready=1 in the next cycle.
- Reset mid-frame: beats 9, 9 accepted, then rst for 1 cycle, then beat 4 (last) → out_sum=4, out_cnt=1, out_ovf=0.
- Upstream stall: in_valid toggles 1,0,0,1 with beats 10, 20 (last) → idle cycles do not alter acc or cnt; result out_sum=30, out_cnt=2.
